// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: digit count, blank pattern
// and the active-low hex glyph table (gfedcba, bit 0 = segment a).
package seg_pkg;

  localparam int DIGITS = 8;
  localparam int DIGIT_W = $clog2(DIGITS);

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the glyph for hex value n; listed from F down to 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,  // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,  // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit to active-low seven-segment decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/seg_display.sv
// Free-running 8-digit multiplexed hex display. Latches the printed word,
// blanks leading zeros and blinks the decimal points after halt. Runs on the
// ungated board clock so the display keeps refreshing after the CPU stops.
module seg_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64,
  parameter int LZ_BLANK     = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Data,
  input  logic        Load,
  input  logic        Halt,
  output logic [7:0]  AN,
  output logic [7:0]  SEG
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SW-1:0]      r_scan_cnt;
  logic [DIGIT_W-1:0] r_digit;
  logic [FW-1:0]      r_frame_cnt;
  logic               r_blink;
  logic [31:0]        r_value;
  logic               r_halted;
  logic [7:0]         r_an;
  logic [7:0]         r_seg;

  logic               w_scan_wrap;
  logic               w_frame_end;
  logic               w_frame_wrap;
  logic [DIGITS-1:0]  w_blank;
  logic [3:0]         w_nib;
  logic [6:0]         w_seg7;
  logic               w_cur_blank;

  assign w_scan_wrap  = (r_scan_cnt == SW'(SCAN_DIV - 1));
  assign w_frame_end  = w_scan_wrap && (r_digit == DIGIT_W'(DIGITS - 1));
  assign w_frame_wrap = w_frame_end && (r_frame_cnt == FW'(BLINK_FRAMES - 1));

  // Dwell counter and digit pointer; digit advances when the dwell expires.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
    end else if (w_scan_wrap) begin
      r_scan_cnt <= '0;
      r_digit    <= r_digit + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Frame counter; the blink phase flips once every BLINK_FRAMES frames.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= '0;
      r_blink     <= ~r_blink;
    end else if (w_frame_end) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // Displayed word and sticky halt flag; a load racing the halt still lands.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_value  <= '0;
      r_halted <= 1'b0;
    end else begin
      if (Load && !r_halted) r_value <= Data;
      if (Halt) r_halted <= 1'b1;
    end
  end

  // Digit k is a leading zero when nibbles k..7 are all zero; digit 0 always shows.
  assign w_blank[0] = 1'b0;
  for (genvar k = 1; k < DIGITS; k++) begin : g_blank
    if (LZ_BLANK != 0) begin : g_lz
      assign w_blank[k] = ((r_value >> (4 * k)) == 32'd0);
    end else begin : g_nolz
      assign w_blank[k] = 1'b0;
    end
  end

  assign w_nib       = r_value[{r_digit, 2'b00} +: 4];
  assign w_cur_blank = w_blank[r_digit];

  hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (w_seg7)
  );

  // Anode and segment drives registered together so they change on the same edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_an  <= 8'hFF;
      r_seg <= 8'hFF;
    end else if (w_cur_blank) begin
      r_an  <= 8'hFF;
      r_seg <= {1'b1, SEG_BLANK};
    end else begin
      r_an  <= ~(8'd1 << r_digit);
      r_seg <= {~(r_halted & r_blink), w_seg7};
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;

endmodule

// File: tb/tb_seg_display.sv
// Directed bench for seg_display with SCAN_DIV=4, BLINK_FRAMES=2. Two
// instances share the stimulus: one with leading-zero blanking, one without.
module tb_seg_display;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] Data;
  logic        Load;
  logic        Halt;
  logic [7:0]  AN1, SEG1, AN0, SEG0;

  int n_tot = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  seg_display #(.SCAN_DIV(4), .BLINK_FRAMES(2), .LZ_BLANK(1)) dut (
    .Clock(Clock), .Reset(Reset), .Data(Data), .Load(Load), .Halt(Halt),
    .AN(AN1), .SEG(SEG1)
  );

  seg_display #(.SCAN_DIV(4), .BLINK_FRAMES(2), .LZ_BLANK(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .Data(Data), .Load(Load), .Halt(Halt),
    .AN(AN0), .SEG(SEG0)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s d%0d {AN,SEG} got=%h want=%h", tag, d, obs, exp);
    end
  endtask

  // One full 32-cycle frame starting at digit 0; the optional load/halt is
  // presented on the frame's last cycle so its effect starts with the next frame.
  task automatic run_frame(input string tag,
                           input logic [7:0][15:0] e1, input logic [7:0][15:0] e0,
                           input logic ld, input logic [31:0] d, input logic hl);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (k == 7 && c == 3) begin
          Load = ld; Data = d; Halt = hl;
        end
        tick();
        Load = 1'b0; Halt = 1'b0;
        chk({tag, "_lz"}, k, {AN1, SEG1}, e1[k]);
        chk({tag, "_nolz"}, k, {AN0, SEG0}, e0[k]);
      end
    end
  endtask

  localparam logic [7:0][15:0] Z1 =
    {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFEC0};
  localparam logic [7:0][15:0] Z0 =
    {16'h7FC0, 16'hBFC0, 16'hDFC0, 16'hEFC0, 16'hF7C0, 16'hFBC0, 16'hFDC0, 16'hFEC0};
  localparam logic [7:0][15:0] V_ABCD =
    {16'h7FF9, 16'hBFA4, 16'hDFB0, 16'hEF99, 16'hF788, 16'hFB83, 16'hFDC6, 16'hFEA1};
  localparam logic [7:0][15:0] VF0_1 =
    {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFD8E, 16'hFEC0};
  localparam logic [7:0][15:0] VF0_0 =
    {16'h7FC0, 16'hBFC0, 16'hDFC0, 16'hEFC0, 16'hF7C0, 16'hFBC0, 16'hFD8E, 16'hFEC0};
  localparam logic [7:0][15:0] VF0_1D =
    {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFD0E, 16'hFE40};
  localparam logic [7:0][15:0] VF0_0D =
    {16'h7F40, 16'hBF40, 16'hDF40, 16'hEF40, 16'hF740, 16'hFB40, 16'hFD0E, 16'hFE40};
  localparam logic [7:0][15:0] V5_1 =
    {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFE92};
  localparam logic [7:0][15:0] V5_0 =
    {16'h7FC0, 16'hBFC0, 16'hDFC0, 16'hEFC0, 16'hF7C0, 16'hFBC0, 16'hFDC0, 16'hFE92};
  localparam logic [7:0][15:0] V5_1D =
    {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFE12};
  localparam logic [7:0][15:0] V5_0D =
    {16'h7F40, 16'hBF40, 16'hDF40, 16'hEF40, 16'hF740, 16'hFB40, 16'hFD40, 16'hFE12};

  initial begin
    Reset = 1'b1; Data = '0; Load = 1'b0; Halt = 1'b0;
    #1;
    chk("rst_async", 0, {AN1, SEG1}, 16'hFFFF);
    repeat (3) tick();
    chk("rst_hold", 0, {AN1, SEG1}, 16'hFFFF);
    chk("rst_hold_nolz", 0, {AN0, SEG0}, 16'hFFFF);
    Reset = 1'b0;

    // Frame 1 (blink 0): Value=0; load 1234ABCD at its end.
    run_frame("zero", Z1, Z0, 1'b1, 32'h1234ABCD, 1'b0);
    // Frame 2 (blink 0): full word, nothing blanked.
    run_frame("abcd", V_ABCD, V_ABCD, 1'b1, 32'h0000_00F0, 1'b0);
    // Frame 3 (blink 1, not halted): dp dark; halt pulse at its end.
    run_frame("f0", VF0_1, VF0_0, 1'b0, 32'h0, 1'b1);
    // Frame 4 (blink 1, halted): dp lit on shown digits; a load is ignored.
    run_frame("f0_dp", VF0_1D, VF0_0D, 1'b1, 32'hFFFF_FFFF, 1'b0);
    // Frames 5,6 (blink 0): dp dark again; value unchanged.
    run_frame("f0_b0a", VF0_1, VF0_0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_frame("f0_b0b", VF0_1, VF0_0, 1'b0, 32'h0, 1'b0);
    // Frame 7 (blink 1): dp back on.
    run_frame("f0_b1", VF0_1D, VF0_0D, 1'b0, 32'h0, 1'b0);

    // Restart; load and halt on the same cycle.
    #2 Reset = 1'b1;
    #1;
    chk("rst_mid", 0, {AN1, SEG1}, 16'hFFFF);
    chk("rst_mid_nolz", 0, {AN0, SEG0}, 16'hFFFF);
    tick();
    Reset = 1'b0;
    run_frame("clr", Z1, Z0, 1'b1, 32'h5, 1'b1);
    run_frame("v5_b0", V5_1, V5_0, 1'b0, 32'h0, 1'b0);
    run_frame("v5_b1", V5_1D, V5_0D, 1'b0, 32'h0, 1'b0);

    // Into frame 4 (blink 1): digits 0..4, then two cycles of digit 5.
    repeat (22) tick();
    chk("d5", 5, {AN1, SEG1}, 16'hFFFF);
    chk("d5_nolz", 5, {AN0, SEG0}, 16'hDF40);
    #2 Reset = 1'b1;
    #1;
    chk("rst_d5", 5, {AN1, SEG1}, 16'hFFFF);
    chk("rst_d5_nolz", 5, {AN0, SEG0}, 16'hFFFF);
    tick();
    chk("rst_d5_hold", 5, {AN0, SEG0}, 16'hFFFF);
    Reset = 1'b0;
    // Value and halt cleared, scan restarts at digit 0.
    run_frame("post", Z1, Z0, 1'b0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
